// File: rtl/vco_nco_mphase.sv
// vco_nco_mphase
//   Clocked multi-phase NCO model of the sinusoidal VCO. A 2^ACC_W phase
//   accumulator advances by a frequency control word (fcw) every clk. The
//   target fcw comes from the coarse tune code plus the analog control
//   voltage, clamped to [FMIN, FMAX]. fcw is slew limited toward that target.
//   NPHASE equally spaced phases are produced, each with a real sinusoid and
//   a square clock, for the CDR interpolator/sampler models.
//
// Ports
//   clk        in   sample clock (FS)
//   rst        in   synchronous, active-high reset
//   en         in   oscillator enable
//   vco_in     in   real control voltage
//   tune       in   coarse tune code (unsigned, TUNE_W bits)
//   tune_load  in   capture tune on this edge
//   tune_ack   out  one-cycle pulse after a tune capture
//   fcw        out  current slewed frequency control word
//   phase      out  packed phases, phase k in [k*ACC_W +: ACC_W]
//   vout       out  vout[k] = VMAG*sin(2*pi*phase_k/2^ACC_W)
//   clk_out    out  clk_out[k] = MSB of phase_k
//   settled    out  fcw has reached the clamped target
//   wrap_cnt   out  saturating count of accumulator wraps
module vco_nco_mphase #(
  parameter int  NPHASE      = 4,
  parameter int  ACC_W       = 32,
  parameter int  TUNE_W      = 5,
  parameter int  TUNE_MID    = 15,
  parameter real CENTER_FREQ = 7.0e6,
  parameter real TUNE_STEP   = 1.0e5,
  parameter real VCO_GAIN    = 2.0e6,
  parameter real VCOIN_MID   = 1.5,
  parameter real FS          = 500.0e6,
  parameter real FMIN        = 1.0e6,
  parameter real FMAX        = 20.0e6,
  parameter int  SLEW_STEP   = 2**16,
  parameter real VMAG        = 0.8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  real                      vco_in,
  input  logic [TUNE_W-1:0]        tune,
  input  logic                     tune_load,
  output logic                     tune_ack,
  output logic [ACC_W-1:0]         fcw,
  output logic [NPHASE*ACC_W-1:0]  phase,
  output real                      vout [NPHASE],
  output logic [NPHASE-1:0]        clk_out,
  output logic                     settled,
  output logic [15:0]              wrap_cnt
);

  localparam real TWO_PI      = 2.0 * 3.14159265358979323846;
  localparam real TWO_POW_ACC = 2.0 ** ACC_W;
  localparam longint unsigned PH_SPACING = (64'd1 << ACC_W) / 64'(NPHASE);

  typedef enum logic [1:0] {
    IDLE,
    SLEW,
    LOCK
  } stateT;

  stateT              state;
  logic [ACC_W-1:0]   acc;
  logic [TUNE_W-1:0]  tuneQ;

  // Target frequency and fcw
  real                fTarget;
  real                fClamped;
  real                tgtReal;
  logic [ACC_W-1:0]   tgt;

  // Slew arithmetic
  logic               tgtAbove;
  logic [ACC_W-1:0]   diffMag;
  logic               bigJump;
  logic [ACC_W-1:0]   stepLimited;
  logic [ACC_W-1:0]   fcwSlewed;

  // Accumulator update
  logic [ACC_W-1:0]   accSum;
  logic               accCarry;

  // Next-cycle output values derived from the current accumulator
  logic [ACC_W-1:0]        phaseK [NPHASE];
  logic [NPHASE*ACC_W-1:0] phaseNext;
  logic [NPHASE-1:0]       clkNext;
  real                     voutNext [NPHASE];

  always_comb begin
    fTarget = CENTER_FREQ
            + (real'(tuneQ) - real'(TUNE_MID)) * TUNE_STEP
            + (vco_in - VCOIN_MID) * VCO_GAIN;
    fClamped = fTarget;
    if (fClamped < FMIN) fClamped = FMIN;
    if (fClamped > FMAX) fClamped = FMAX;
    tgtReal = fClamped / FS * TWO_POW_ACC;
    // real-to-integer cast rounds to nearest
    tgt = ACC_W'(longint'(tgtReal));
  end

  always_comb begin
    tgtAbove    = tgt > fcw;
    diffMag     = tgtAbove ? (tgt - fcw) : (fcw - tgt);
    // compare in 64 bits so a narrow accumulator never truncates SLEW_STEP
    bigJump     = 64'(diffMag) > 64'(SLEW_STEP);
    stepLimited = bigJump ? ACC_W'(SLEW_STEP) : diffMag;
    fcwSlewed   = tgtAbove ? (fcw + stepLimited) : (fcw - stepLimited);
  end

  always_comb begin
    {accCarry, accSum} = {1'b0, acc} + {1'b0, fcw};
  end

  always_comb begin
    phaseNext = '0;
    clkNext   = '0;
    for (int unsigned k = 0; k < NPHASE; k++) begin
      phaseK[k]   = acc + ACC_W'(64'(k) * PH_SPACING);
      phaseNext[k*ACC_W +: ACC_W] = phaseK[k];
      clkNext[k]  = phaseK[k][ACC_W-1];
      voutNext[k] = VMAG * $sin(TWO_PI * real'(phaseK[k]) / TWO_POW_ACC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      fcw      <= '0;
      settled  <= 1'b0;
      wrap_cnt <= '0;
      tuneQ    <= TUNE_W'(TUNE_MID);
      tune_ack <= 1'b0;
      phase    <= '0;
      clk_out  <= '0;
      for (int unsigned k = 0; k < NPHASE; k++) vout[k] <= 0.0;
    end else begin
      tune_ack <= tune_load;
      if (tune_load) tuneQ <= tune;

      // Outputs lag the accumulator by one clk; held at zero while idle.
      if (state == IDLE) begin
        phase   <= '0;
        clk_out <= '0;
        for (int unsigned k = 0; k < NPHASE; k++) vout[k] <= 0.0;
      end else begin
        phase   <= phaseNext;
        clk_out <= clkNext;
        for (int unsigned k = 0; k < NPHASE; k++) vout[k] <= voutNext[k];
      end

      case (state)
        IDLE: begin
          acc      <= '0;
          fcw      <= '0;
          settled  <= 1'b0;
          wrap_cnt <= '0;
          if (en) begin
            // cold start: jump straight to target, no slew
            state <= SLEW;
            fcw   <= tgt;
          end
        end
        SLEW, LOCK: begin
          if (!en) begin
            state   <= IDLE;
            acc     <= '0;
            fcw     <= '0;
            settled <= 1'b0;
          end else begin
            // acc is never reloaded here, so retargeting keeps phase continuous
            acc <= accSum;
            if (accCarry && (wrap_cnt != '1)) wrap_cnt <= wrap_cnt + 16'd1;
            if (state == SLEW) begin
              fcw <= fcwSlewed;
              if (fcwSlewed == tgt) begin
                state   <= LOCK;
                settled <= 1'b1;
              end else begin
                settled <= 1'b0;
              end
            end else if (bigJump) begin
              state   <= SLEW;
              fcw     <= fcwSlewed;
              settled <= 1'b0;
            end else begin
              fcw     <= tgt;
              settled <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vco_nco_mphase.sv
module tb_vco_nco_mphase;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance, default parameters
  logic         rst = 1'b1;
  logic         en = 1'b0;
  real          vcoIn = 1.5;
  logic [4:0]   tune = 5'd15;
  logic         tuneLoad = 1'b0;
  logic         tuneAck;
  logic [31:0]  fcw;
  logic [127:0] phase;
  real          vout [4];
  logic [3:0]   clkOut;
  logic         settled;
  logic [15:0]  wrapCnt;

  vco_nco_mphase dut (
    .clk(clk), .rst(rst), .en(en), .vco_in(vcoIn), .tune(tune),
    .tune_load(tuneLoad), .tune_ack(tuneAck), .fcw(fcw), .phase(phase),
    .vout(vout), .clk_out(clkOut), .settled(settled), .wrap_cnt(wrapCnt)
  );

  // Narrow instance whose FCW is 255/256 of full scale: a wrap almost every clk
  logic         rst2 = 1'b1;
  logic         en2 = 1'b0;
  real          vcoIn2 = 1.5;
  logic [4:0]   tune2 = 5'd15;
  logic         tuneLoad2 = 1'b0;
  logic         tuneAck2;
  logic [7:0]   fcw2;
  logic [31:0]  phase2;
  real          vout2 [4];
  logic [3:0]   clkOut2;
  logic         settled2;
  logic [15:0]  wrapCnt2;

  vco_nco_mphase #(
    .ACC_W(8),
    .FS(20.0e6 * 256.0 / 255.0)
  ) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .vco_in(vcoIn2), .tune(tune2),
    .tune_load(tuneLoad2), .tune_ack(tuneAck2), .fcw(fcw2), .phase(phase2),
    .vout(vout2), .clk_out(clkOut2), .settled(settled2), .wrap_cnt(wrapCnt2)
  );

  typedef enum {
    K_FCW, K_SET, K_ACK, K_PH0, K_PHD, K_CLK, K_WRAP, K_V0, K_V1,
    K_FCW2, K_SET2, K_WRAP2
  } kindT;

  typedef struct {
    int unsigned     cyc;
    kindT            kind;
    longint unsigned exp;
    real             expR;
    string           name;
  } itemT;

  itemT sb[$];
  int   nTests = 0;
  int   nFail  = 0;

  task automatic expectAt(input int unsigned offs, input kindT k,
                          input longint unsigned v, input string nm);
    itemT it;
    it.cyc = cyc + offs; it.kind = k; it.exp = v; it.expR = 0.0; it.name = nm;
    sb.push_back(it);
  endtask

  task automatic expectReal(input int unsigned offs, input kindT k,
                            input real v, input string nm);
    itemT it;
    it.cyc = cyc + offs; it.kind = k; it.exp = 0; it.expR = v; it.name = nm;
    sb.push_back(it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned sampleInt(input kindT k);
    case (k)
      K_FCW:   return 64'(fcw);
      K_SET:   return 64'(settled);
      K_ACK:   return 64'(tuneAck);
      K_PH0:   return 64'(phase[31:0]);
      K_PHD:   return 64'(32'(phase[63:32] - phase[31:0]));
      K_CLK:   return 64'(clkOut);
      K_WRAP:  return 64'(wrapCnt);
      K_FCW2:  return 64'(fcw2);
      K_SET2:  return 64'(settled2);
      K_WRAP2: return 64'(wrapCnt2);
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  task automatic checkItem(input itemT it);
    nTests++;
    if (it.kind == K_V0 || it.kind == K_V1) begin
      real act;
      act = (it.kind == K_V0) ? vout[0] : vout[1];
      if (act - it.expR > 1.0e-6 || it.expR - act > 1.0e-6) begin
        nFail++;
        $display("FAIL %s @cyc %0d: got %f, want %f", it.name, cyc, act, it.expR);
      end
    end else begin
      longint unsigned act;
      act = sampleInt(it.kind);
      if (act != it.exp) begin
        nFail++;
        $display("FAIL %s @cyc %0d: got %0d, want %0d", it.name, cyc, act, it.exp);
      end
    end
  endtask

  // Monitor: samples on the falling edge, pops every entry due this cycle
  initial begin : monitor
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          checkItem(sb[i]);
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          nTests++;
          nFail++;
          $display("FAIL %s: due cyc %0d never sampled (now %0d)", sb[i].name, sb[i].cyc, cyc);
          sb.delete(i);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset state, sampled after two reset edges
    expectAt(2, K_FCW, 0, "rst_fcw");
    expectAt(2, K_SET, 0, "rst_settled");
    expectAt(2, K_ACK, 0, "rst_ack");
    expectAt(2, K_PH0, 0, "rst_phase0");
    expectAt(2, K_CLK, 0, "rst_clkout");
    expectAt(2, K_WRAP, 0, "rst_wrap");
    expectReal(2, K_V1, 0.0, "rst_vout1");
    tick(2);
    rst  = 1'b0;
    rst2 = 1'b0;

    // Narrow instance: fcw=255, k-th add carries unless k-1 is a multiple of 256
    en2    = 1'b1;
    vcoIn2 = 30.0;
    expectAt(1, K_FCW2, 255, "sat_fcw");
    expectAt(2, K_SET2, 1, "sat_settled");
    expectAt(65792, K_WRAP2, 65534, "sat_wrap_pre");
    expectAt(65793, K_WRAP2, 65535, "sat_wrap_hit");
    expectAt(65803, K_WRAP2, 65535, "sat_wrap_hold");

    // Back-to-back tune loads while idle
    tune = 5'd16; tuneLoad = 1'b1;
    expectAt(1, K_ACK, 1, "ack_first");
    tick(1);
    tune = 5'd15;
    expectAt(1, K_ACK, 1, "ack_second");
    tick(1);
    tuneLoad = 1'b0;
    expectAt(1, K_ACK, 0, "ack_clear");
    tick(1);

    // Cold start at tune=15, vco_in=1.5 -> 7 MHz
    en = 1'b1;
    expectAt(1, K_FCW, 60129542, "cold_fcw");
    expectAt(1, K_SET, 0, "cold_settled_early");
    expectAt(2, K_SET, 1, "cold_settled");
    expectAt(2, K_FCW, 60129542, "cold_fcw_hold");
    expectAt(2, K_PH0, 0, "cold_phase0_first");
    expectAt(2, K_PHD, 64'h4000_0000, "cold_phase_spacing");
    expectAt(2, K_CLK, 4'b1100, "cold_clkout_first");
    expectReal(2, K_V0, 0.0, "cold_vout0");
    expectReal(2, K_V1, 0.8, "cold_vout1_quadrature");
    expectAt(3, K_PH0, 60129542, "cold_phase0_step");
    expectAt(3, K_CLK, 4'b1100, "cold_clkout_step");
    expectAt(72, K_WRAP, 0, "wrap_before_first");
    expectAt(73, K_WRAP, 1, "wrap_first");
    tick(80);

    // Retune to 20 -> 7.5 MHz, slews in 65536 steps
    tune = 5'd20; tuneLoad = 1'b1;
    expectAt(1, K_ACK, 1, "retune_ack");
    expectAt(2, K_ACK, 0, "retune_ack_pulse");
    expectAt(2, K_FCW, 60195078, "slew_first_step");
    expectAt(2, K_SET, 0, "slew_unsettled");
    expectAt(30, K_PHD, 64'h4000_0000, "slew_phase_spacing");
    expectAt(66, K_FCW, 64389382, "slew_last_full_step");
    expectAt(66, K_SET, 0, "slew_still_unsettled");
    expectAt(67, K_FCW, 64424509, "slew_final");
    expectAt(67, K_SET, 1, "slew_settled");
    tick(1);
    tuneLoad = 1'b0;
    tick(70);

    // Disable, then clamp to FMAX by cold start
    en = 1'b0;
    expectAt(1, K_FCW, 0, "idle_fcw");
    expectAt(1, K_SET, 0, "idle_settled");
    expectAt(2, K_PH0, 0, "idle_phase0");
    expectAt(2, K_CLK, 0, "idle_clkout");
    expectReal(2, K_V1, 0.0, "idle_vout1");
    tick(1);
    vcoIn = 20.0; en = 1'b1;
    expectAt(1, K_FCW, 171798692, "clamp_fmax");
    expectAt(2, K_SET, 1, "clamp_fmax_settled");
    tick(3);
    en = 1'b0;
    tick(1);
    vcoIn = -10.0; en = 1'b1;
    expectAt(1, K_FCW, 8589935, "clamp_fmin");
    expectAt(2, K_SET, 1, "clamp_fmin_settled");
    tick(3);

    // Large upward retarget, then reset mid-slew with en held high
    vcoIn = 1.5;
    expectAt(1, K_FCW, 8655471, "rslew_step1");
    expectAt(1, K_SET, 0, "rslew_unsettled");
    expectAt(2, K_FCW, 8721007, "rslew_step2");
    tick(5);
    rst = 1'b1;
    expectAt(1, K_FCW, 0, "midrst_fcw");
    expectAt(1, K_SET, 0, "midrst_settled");
    expectAt(1, K_PH0, 0, "midrst_phase0");
    expectAt(1, K_CLK, 0, "midrst_clkout");
    expectAt(1, K_WRAP, 0, "midrst_wrap");
    expectAt(1, K_ACK, 0, "midrst_ack");
    expectReal(1, K_V0, 0.0, "midrst_vout0");
    tick(1);
    rst = 1'b0;
    // tune_q back at 15 gives the 7 MHz word again
    expectAt(1, K_FCW, 60129542, "relock_fcw");
    expectAt(2, K_SET, 1, "relock_settled");
    tick(4);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 70000 && sb.size() > 0; i++) tick(1);
    while (sb.size() > 0) begin
      nTests++;
      nFail++;
      $display("FAIL %s: timed out waiting for cyc %0d", sb[0].name, sb[0].cyc);
      sb.delete(0);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
